register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DataWidth, default 16: width of every register and of DIn/SRC1/SRC2.
REQ-002 Parameter SelectSize, default 3: register address width; register count = 2**SelectSize (8 by default).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_N  input  1  reset, asynchronous, active-low.
REQ-005 REG_WE  input  1  write enable, active-low (0 = write, 1 = hold).
REQ-006 DIn  input  DataWidth  write data.
REQ-007 REG_Dst  input  SelectSize  destination register index for writes.
REQ-008 REG_Src1  input  SelectSize  read-port-1 register index.
REQ-009 REG_Src2  input  SelectSize  read-port-2 register index.
REQ-010 SRC1  output  DataWidth  contents of register REG_Src1.
REQ-011 SRC2  output  DataWidth  contents of register REG_Src2.

Function
REQ-012 The block SHALL hold 2**SelectSize registers of DataWidth bits, all general-purpose and writable; register 0 is NOT hardwired to zero.
REQ-013 On a rising Clk edge with Reset_N=1 and REG_WE=0, register[REG_Dst] SHALL load DIn; all other registers hold.
REQ-014 With REG_WE=1, no register SHALL change.
REQ-015 Reads SHALL be combinational: SRC1 = register[REG_Src1], SRC2 = register[REG_Src2], valid after input settling, no clock latency.
REQ-016 Both read ports SHALL be independent; REG_Src1 = REG_Src2 SHALL be legal and give identical outputs.
REQ-017 Read-during-write to the same index: before the edge, the port SHALL show the old value; immediately after the edge, the new value (no write-through bypass).
REQ-018 Write latency SHALL be one edge: data presented before rising edge N is readable right after edge N.
REQ-019 X/Z on REG_WE is out of spec; no behaviour is guaranteed.

Reset
REQ-020 Reset_N=0 SHALL immediately (asynchronously) clear every register to 0, so SRC1=SRC2=0 regardless of selects.
REQ-021 While Reset_N=0, writes SHALL be ignored even with REG_WE=0.
REQ-022 Reset assertion coinciding with a write edge SHALL leave all registers 0; release is synchronised externally by the caller.

Structure
REQ-023 Shared package SHALL hold default constants DATA_WIDTH=16, SELECT_SIZE=3 and the register-count derivation.
REQ-024 The block SHALL be a single module (storage array + write decode + two read muxes); an optional sub-module reg_cell (one DataWidth register with async active-low clear and load enable) MAY be instantiated per entry.

Verification
REQ-025 Reset: assert Reset_N=0 after writes -> SRC1=SRC2=0x0000 for all selects, without a clock edge.
REQ-026 Basic write: REG_WE=0, DIn=0x00A0, REG_Dst=0, REG_Src1=0, one rising edge -> SRC1=0x00A0 50 ns after edge.
REQ-027 Write inhibit: REG_WE=1, DIn=0xFFFF, REG_Dst=0, edge -> SRC1 stays 0x00A0.
REQ-028 Fill all: write reg i = 0x1110+i for i=0..7, then sweep Src1 0..7 and Src2 7..0 -> each port returns the matching value simultaneously.
REQ-029 Read-during-write: Src1=Dst=3 holding 0x1113, write 0xBEEF -> SRC1=0x1113 before edge, 0xBEEF after; SRC2 on reg 4 unchanged 0x1114.
REQ-030 Reset during write: Reset_N=0 with REG_WE=0, DIn=0x5555 across an edge -> all registers read 0x0000.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared defaults for the register file: data width, select width and
// the register-count derivation used by the top module.
package register_file_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int SELECT_SIZE = 3;

    function automatic int reg_count(input int select_size);
        return 1 << select_size;
    endfunction

    localparam int REG_COUNT = reg_count(SELECT_SIZE);

endpackage

// File: rtl/register_file.sv
// General-purpose register file: one active-low-enabled write port and two
// independent combinational read ports, with asynchronous active-low clear.
module register_file
    import register_file_pkg::*;
#(
    parameter int DataWidth  = DATA_WIDTH,
    parameter int SelectSize = SELECT_SIZE
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  REG_WE,
    input  logic [DataWidth-1:0]  DIn,
    input  logic [SelectSize-1:0] REG_Dst,
    input  logic [SelectSize-1:0] REG_Src1,
    input  logic [SelectSize-1:0] REG_Src2,
    output logic [DataWidth-1:0]  SRC1,
    output logic [DataWidth-1:0]  SRC2
);

    localparam int NumRegs = reg_count(SelectSize);

    logic [DataWidth-1:0] regs [NumRegs];

    // Register 0 is ordinary storage; no entry is hardwired.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (!REG_WE) begin
            regs[REG_Dst] <= DIn;
        end
    end

    // Reads come straight from storage, so a same-cycle write is visible
    // only after the edge that commits it.
    assign SRC1 = regs[REG_Src1];
    assign SRC2 = regs[REG_Src2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table for writes/reads plus
// hand-written reset and read-during-write sequences.
module tb_register_file;

    logic        Clk;
    logic        Reset_N;
    logic        REG_WE;
    logic [15:0] DIn;
    logic [2:0]  REG_Dst;
    logic [2:0]  REG_Src1;
    logic [2:0]  REG_Src2;
    logic [15:0] SRC1;
    logic [15:0] SRC2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we_n;
        logic [15:0] din;
        logic [2:0]  dst;
        logic [2:0]  src1;
        logic [2:0]  src2;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } vec_t;

    vec_t vecs [18];

    register_file #(
        .DataWidth (16),
        .SelectSize(3)
    ) dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .REG_WE  (REG_WE),
        .DIn     (DIn),
        .REG_Dst (REG_Dst),
        .REG_Src1(REG_Src1),
        .REG_Src2(REG_Src2),
        .SRC1    (SRC1),
        .SRC2    (SRC2)
    );

    initial Clk = 1'b0;
    always #50 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int s = 0; s < 8; s++) begin
            REG_Src1 = 3'(s);
            REG_Src2 = 3'(7 - s);
            #1;
            check({name, "_src1"}, SRC1, 16'h0000);
            check({name, "_src2"}, SRC2, 16'h0000);
        end
    endtask

    initial begin
        // Basic write to reg 0, then an inhibited write that must not land.
        vecs[0] = '{1'b0, 16'h00A0, 3'd0, 3'd0, 3'd0, 16'h00A0, 16'h00A0};
        vecs[1] = '{1'b1, 16'hFFFF, 3'd0, 3'd0, 3'd0, 16'h00A0, 16'h00A0};
        for (int i = 0; i < 8; i++) begin
            vecs[2 + i] = '{1'b0, 16'h1110 + 16'(i), 3'(i), 3'(i), 3'd0,
                            16'h1110 + 16'(i), 16'h1110};
        end
        for (int i = 0; i < 8; i++) begin
            vecs[10 + i] = '{1'b1, 16'h0000, 3'd0, 3'(i), 3'(7 - i),
                             16'h1110 + 16'(i), 16'h1117 - 16'(i)};
        end

        Reset_N  = 1'b0;
        REG_WE   = 1'b1;
        DIn      = '0;
        REG_Dst  = '0;
        REG_Src1 = '0;
        REG_Src2 = '0;
        #10;
        check_all_zero("reset_init");
        @(negedge Clk);
        Reset_N = 1'b1;

        // Table: drive at negedge, sample 50 ns after the committing edge.
        for (int v = 0; v < 18; v++) begin
            @(negedge Clk);
            REG_WE   = vecs[v].we_n;
            DIn      = vecs[v].din;
            REG_Dst  = vecs[v].dst;
            REG_Src1 = vecs[v].src1;
            REG_Src2 = vecs[v].src2;
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("vec%0d_src1", v), SRC1, vecs[v].exp1);
            check($sformatf("vec%0d_src2", v), SRC2, vecs[v].exp2);
        end

        // Read-during-write on reg 3 while port 2 watches reg 4.
        @(negedge Clk);
        REG_WE   = 1'b0;
        DIn      = 16'hBEEF;
        REG_Dst  = 3'd3;
        REG_Src1 = 3'd3;
        REG_Src2 = 3'd4;
        #1;
        check("rdw_before_src1", SRC1, 16'h1113);
        check("rdw_before_src2", SRC2, 16'h1114);
        @(posedge Clk);
        #1;
        check("rdw_after_src1", SRC1, 16'hBEEF);
        check("rdw_after_src2", SRC2, 16'h1114);
        @(negedge Clk);
        REG_WE = 1'b1;

        // Same select on both ports.
        REG_Src1 = 3'd5;
        REG_Src2 = 3'd5;
        #1;
        check("same_sel_src1", SRC1, 16'h1115);
        check("same_sel_src2", SRC2, 16'h1115);

        // Asynchronous clear mid low phase, no clock edge in between.
        #5;
        Reset_N = 1'b0;
        #1;
        check_all_zero("reset_async");

        // Write attempted across an edge while reset is held.
        @(negedge Clk);
        REG_WE  = 1'b0;
        DIn     = 16'h5555;
        REG_Dst = 3'd2;
        @(posedge Clk);
        #1;
        check_all_zero("reset_during_write");
        @(negedge Clk);
        REG_WE  = 1'b1;
        Reset_N = 1'b1;
        @(posedge Clk);
        #1;
        check_all_zero("after_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
